// File: rtl/msd_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// msd_cmd_sequencer
//
// DDR5 command sequencer sitting between the memory-controller request queue
// and the DIMM command bus. One request (operation + 36-bit physical address)
// is accepted per handshake, its address is decoded into channel / bank group /
// bank / column / row, and the two-cycle ACT, two-cycle RD or WR and a PRE are
// issued while DRAM timing is enforced with saturating cycle counters.
//
// Build option:
//   MSD_OPEN_PAGE_EN  - when defined, rows are left open and tracked in a
//                       64-entry open-row table; a row hit goes straight to
//                       CAS, a row miss precharges first, and no trailing PRE
//                       is issued. When undefined the closed-page policy is
//                       used and no table exists.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous, active-high reset
//   req_valid    in   request present at the queue head
//   req_ready    out  sequencer can accept a request (IDLE only)
//   req_oper     in   0 data read, 1 instruction fetch, 2 write, 3 illegal
//   req_addr     in   36-bit physical address
//   cmd_valid    out  a command is on the bus this cycle
//   cmd_code     out  0 NOP,1 ACT0,2 ACT1,3 RD0,4 RD1,5 WR0,6 WR1,7 PRE
//   cmd_channel  out  addr[6]
//   cmd_bg       out  addr[9:7]
//   cmd_bank     out  addr[11:10]
//   cmd_col      out  addr[17:12]
//   cmd_row      out  addr[33:18]
//   done         out  one-cycle pulse when a request completes
//   err          out  one-cycle pulse when an illegal operation is dropped
// ---------------------------------------------------------------------------
module msd_cmd_sequencer #(
    parameter int T_RCD   = 39,
    parameter int T_RAS   = 76,
    parameter int T_RP    = 39,
    parameter int T_RTP   = 18,
    parameter int T_CWD   = 38,
    parameter int T_BURST = 8,
    parameter int T_WR    = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_oper,
    input  logic [35:0] req_addr,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic        cmd_channel,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [5:0]  cmd_col,
    output logic [15:0] cmd_row,
    output logic        done,
    output logic        err
);

    // The counters are 8 bits wide and saturate, so every timing value has to
    // be reachable by them; the write recovery window is compared against
    // counter+1, which tops out at 256.
    if (T_RCD < 2 || T_RCD > 255 || T_RAS < 2 || T_RAS > 255 ||
        T_RP < 2 || T_RP > 255 || T_RTP < 2 || T_RTP > 255 ||
        T_CWD < 2 || T_CWD > 255 || T_BURST < 2 || T_BURST > 255 ||
        T_WR < 2 || T_WR > 255) begin : gParamRange
        $error("msd_cmd_sequencer: every timing parameter must lie in 2..255");
    end
    if (T_CWD + T_BURST + T_WR > 256) begin : gWriteRecovery
        $error("msd_cmd_sequencer: T_CWD+T_BURST+T_WR must not exceed 256");
    end

    localparam logic [9:0] P_RCD  = 10'(T_RCD);
    localparam logic [9:0] P_RAS  = 10'(T_RAS);
    localparam logic [9:0] P_RP   = 10'(T_RP);
    localparam logic [9:0] P_RTP  = 10'(T_RTP);
    localparam logic [9:0] P_WREC = 10'(T_CWD + T_BURST + T_WR);

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT0 = 3'd1;
    localparam logic [2:0] CMD_ACT1 = 3'd2;
    localparam logic [2:0] CMD_RD0  = 3'd3;
    localparam logic [2:0] CMD_RD1  = 3'd4;
    localparam logic [2:0] CMD_WR0  = 3'd5;
    localparam logic [2:0] CMD_WR1  = 3'd6;
    localparam logic [2:0] CMD_PRE  = 3'd7;

    typedef enum logic [3:0] {
        IDLE, ACT0, ACT1, WAIT_RCD, CAS0, CAS1, WAIT_PRE, PRE, WAIT_RP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_isWrite;
    logic        r_lastWrite;
    logic        r_err;
    logic        r_channel;
    logic [2:0]  r_bg;
    logic [1:0]  r_bank;
    logic [5:0]  r_col;
    logic [15:0] r_row;
    logic [7:0]  r_sinceAct;
    logic [7:0]  r_sinceCas;
    logic [7:0]  r_sincePre;

    logic        w_accept;
    logic        w_illegal;
    logic        w_channel;
    logic [2:0]  w_bg;
    logic [1:0]  w_bank;
    logic [5:0]  w_col;
    logic [15:0] w_row;
    logic [9:0]  w_actPlus;
    logic [9:0]  w_casPlus;
    logic [9:0]  w_prePlus;
    logic        w_rcdOk;
    logic        w_preOk;
    logic        w_rpOk;
    logic        w_unusedAddr;

    assign w_channel    = req_addr[6];
    assign w_bg         = req_addr[9:7];
    assign w_bank       = req_addr[11:10];
    assign w_col        = req_addr[17:12];
    assign w_row        = req_addr[33:18];
    assign w_unusedAddr = ^{req_addr[35:34], req_addr[5:0]};

    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;
    assign w_illegal = (req_oper == 2'd3);

    // Counters hold "cycles since event" for the current cycle, so the value
    // they will have next cycle is counter+1; transitions test that value.
    assign w_actPlus = {2'b00, r_sinceAct} + 10'd1;
    assign w_casPlus = {2'b00, r_sinceCas} + 10'd1;
    assign w_prePlus = {2'b00, r_sincePre} + 10'd1;
    assign w_rcdOk   = (w_actPlus >= P_RCD);
    assign w_rpOk    = (w_prePlus >= P_RP);
    assign w_preOk   = (w_actPlus >= P_RAS) &&
                       (r_lastWrite ? (w_casPlus >= P_WREC) : (w_casPlus >= P_RTP));

`ifdef MSD_OPEN_PAGE_EN
    logic [63:0] r_rowValid;
    logic [15:0] r_rowTable [64];
    logic [5:0]  w_lookIdx;
    logic [5:0]  w_fillIdx;
    logic        w_hit;
    logic        w_miss;

    assign w_lookIdx = {w_channel, w_bg, w_bank};
    assign w_fillIdx = {r_channel, r_bg, r_bank};
    assign w_hit     = r_rowValid[w_lookIdx] && (r_rowTable[w_lookIdx] == w_row);
    assign w_miss    = r_rowValid[w_lookIdx] && (r_rowTable[w_lookIdx] != w_row);

    // A row becomes the open row of its bank when its ACT0 goes out; only
    // the valid bits need clearing on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rowValid <= '0;
        end else if (r_state == ACT0) begin
            r_rowValid[w_fillIdx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ACT0) begin
            r_rowTable[w_fillIdx] <= r_row;
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_illegal) begin
`ifdef MSD_OPEN_PAGE_EN
                    if (w_hit) begin
                        w_next = w_rcdOk ? CAS0 : WAIT_RCD;
                    end else if (w_miss) begin
                        w_next = w_preOk ? PRE : WAIT_PRE;
                    end else begin
                        w_next = ACT0;
                    end
`else
                    w_next = ACT0;
`endif
                end
            end
            ACT0:     w_next = ACT1;
            ACT1:     w_next = w_rcdOk ? CAS0 : WAIT_RCD;
            WAIT_RCD: w_next = w_rcdOk ? CAS0 : WAIT_RCD;
            CAS0:     w_next = CAS1;
`ifdef MSD_OPEN_PAGE_EN
            CAS1:     w_next = IDLE;
`else
            CAS1:     w_next = w_preOk ? PRE : WAIT_PRE;
`endif
            WAIT_PRE: w_next = w_preOk ? PRE : WAIT_PRE;
            PRE:      w_next = WAIT_RP;
`ifdef MSD_OPEN_PAGE_EN
            // Only a row miss precharges, so an ACT always follows.
            WAIT_RP:  w_next = w_rpOk ? ACT0 : WAIT_RP;
`else
            WAIT_RP:  w_next = w_rpOk ? IDLE : WAIT_RP;
`endif
            default:  w_next = IDLE;
        endcase
    end

    // State, decoded request and timing counters. Each counter is zeroed as
    // its event's state is entered, so it reads 0 in the event cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_isWrite   <= 1'b0;
            r_lastWrite <= 1'b0;
            r_err       <= 1'b0;
            r_channel   <= 1'b0;
            r_bg        <= '0;
            r_bank      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_sinceAct  <= '0;
            r_sinceCas  <= '0;
            r_sincePre  <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= w_accept && w_illegal;
            if (w_accept && !w_illegal) begin
                r_isWrite <= (req_oper == 2'd2);
                r_channel <= w_channel;
                r_bg      <= w_bg;
                r_bank    <= w_bank;
                r_col     <= w_col;
                r_row     <= w_row;
            end
            if (r_state == CAS0) begin
                r_lastWrite <= r_isWrite;
            end
            r_sinceAct <= (w_next == ACT0) ? 8'd0 :
                          (r_sinceAct == 8'hFF) ? 8'hFF : r_sinceAct + 8'd1;
            r_sinceCas <= (w_next == CAS0) ? 8'd0 :
                          (r_sinceCas == 8'hFF) ? 8'hFF : r_sinceCas + 8'd1;
            r_sincePre <= (w_next == PRE) ? 8'd0 :
                          (r_sincePre == 8'hFF) ? 8'hFF : r_sincePre + 8'd1;
        end
    end

    // Command bus outputs are decoded from the current state.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_code  = CMD_NOP;
        case (r_state)
            ACT0: begin cmd_valid = 1'b1; cmd_code = CMD_ACT0; end
            ACT1: begin cmd_valid = 1'b1; cmd_code = CMD_ACT1; end
            CAS0: begin cmd_valid = 1'b1; cmd_code = r_isWrite ? CMD_WR0 : CMD_RD0; end
            CAS1: begin cmd_valid = 1'b1; cmd_code = r_isWrite ? CMD_WR1 : CMD_RD1; end
            PRE:  begin cmd_valid = 1'b1; cmd_code = CMD_PRE; end
            default: begin cmd_valid = 1'b0; cmd_code = CMD_NOP; end
        endcase
    end

`ifdef MSD_OPEN_PAGE_EN
    assign done = (r_state == CAS1);
`else
    assign done = (r_state == PRE);
`endif
    assign err         = r_err;
    assign cmd_channel = r_channel;
    assign cmd_bg      = r_bg;
    assign cmd_bank    = r_bank;
    assign cmd_col     = r_col;
    assign cmd_row     = r_row;

endmodule

// File: tb/tb_msd_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_msd_cmd_sequencer
//
// Self-checking bench for msd_cmd_sequencer. Each driven request pushes the
// commands, done and err pulses it should produce (with their cycle numbers)
// onto a scoreboard queue; a monitor pops and compares whenever the DUT shows
// any activity. Cycle 0 is the cycle whose closing edge accepts the request.
// ---------------------------------------------------------------------------
module tb_msd_cmd_sequencer;

    localparam int T_RCD   = 39;
    localparam int T_RAS   = 76;
    localparam int T_RP    = 39;
    localparam int T_RTP   = 18;
    localparam int T_CWD   = 38;
    localparam int T_BURST = 8;
    localparam int T_WR    = 30;

    localparam int K_CLOSED  = 0;
    localparam int K_NOPRE   = 1;
    localparam int K_ILLEGAL = 2;
    localparam int K_HIT     = 3;
    localparam int K_OPENACT = 4;
    localparam int K_MISS    = 5;

    localparam logic [35:0] ADDR_ROW5 = 36'h0_0014_3540;
    localparam logic [35:0] ADDR_ROW6 = 36'h0_0018_3540;

    typedef struct {
        int          cyc;
        logic [2:0]  code;
        logic        isDone;
        logic        isErr;
        logic [35:0] addr;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_oper = 2'd0;
    logic [35:0] req_addr = '0;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic        cmd_channel;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [5:0]  cmd_col;
    logic [15:0] cmd_row;
    logic        done;
    logic        err;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;
    ev_t  sbQ[$];
    ev_t  monEv;

    int   lastAct = -1000;
    int   lastCas = -1000;
    bit   lastWrite = 1'b0;

    msd_cmd_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_oper   (req_oper),
        .req_addr   (req_addr),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_channel(cmd_channel),
        .cmd_bg     (cmd_bg),
        .cmd_bank   (cmd_bank),
        .cmd_col    (cmd_col),
        .cmd_row    (cmd_row),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic pushEvent(input int c, input logic [2:0] code, input logic d, input logic e,
                             input logic [35:0] addr);
        ev_t ev;
        ev.cyc = c; ev.code = code; ev.isDone = d; ev.isErr = e; ev.addr = addr;
        sbQ.push_back(ev);
    endtask

    task automatic waitCycle(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) checkOutput("waitCycle", 36'(cyc), 36'(n));
    endtask

    // Drives one request, accepting on the first ready cycle, and records the
    // expected activity. endCyc is the cycle req_ready should return.
    task automatic applyStimulus(input logic [1:0] oper, input logic [35:0] addr, input int kind,
                                 output int base, output int endCyc);
        int guard = 0;
        int a, c, p;
        logic [2:0] cas0, cas1;
        bit wr;
        do begin
            @(negedge clk);
            guard++;
        end while (!req_ready && guard < 400);
        if (!req_ready) checkOutput("readyTimeout", {35'd0, req_ready}, 36'd1);
        req_valid = 1'b1;
        req_oper  = oper;
        req_addr  = addr;
        base      = cyc;
        endCyc    = base;
        wr   = (oper == 2'd2);
        cas0 = wr ? 3'd5 : 3'd3;
        cas1 = wr ? 3'd6 : 3'd4;
        case (kind)
            K_CLOSED, K_NOPRE: begin
                a = base + 1;
                c = a + T_RCD;
                p = wr ? maxInt(a + T_RAS, c + T_CWD + T_BURST + T_WR)
                       : maxInt(a + T_RAS, c + T_RTP);
                pushEvent(a, 3'd1, 1'b0, 1'b0, addr);
                pushEvent(a + 1, 3'd2, 1'b0, 1'b0, addr);
                pushEvent(c, cas0, 1'b0, 1'b0, addr);
                pushEvent(c + 1, cas1, 1'b0, 1'b0, addr);
                if (kind == K_CLOSED) pushEvent(p, 3'd7, 1'b1, 1'b0, addr);
                endCyc = p + T_RP;
            end
            K_ILLEGAL: begin
                pushEvent(base + 1, 3'd0, 1'b0, 1'b1, addr);
                endCyc = base + 1;
            end
            default: begin
                if (kind == K_HIT) begin
                    c = maxInt(base + 1, lastAct + T_RCD);
                end else begin
                    a = base + 1;
                    if (kind == K_MISS) begin
                        p = maxInt(base + 1, lastAct + T_RAS);
                        p = maxInt(p, lastCas + (lastWrite ? (T_CWD + T_BURST + T_WR) : T_RTP));
                        pushEvent(p, 3'd7, 1'b0, 1'b0, addr);
                        a = p + T_RP;
                    end
                    c = a + T_RCD;
                    pushEvent(a, 3'd1, 1'b0, 1'b0, addr);
                    pushEvent(a + 1, 3'd2, 1'b0, 1'b0, addr);
                    lastAct = a;
                end
                pushEvent(c, cas0, 1'b0, 1'b0, addr);
                pushEvent(c + 1, cas1, 1'b1, 1'b0, addr);
                lastCas   = c;
                lastWrite = wr;
                endCyc    = c + 2;
            end
        endcase
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Scoreboard monitor: any command, done or err must match the oldest
    // outstanding expectation.
    always @(negedge clk) begin
        if (started) begin
            if (cmd_valid || done || err) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedOut", {30'd0, cmd_valid, cmd_code, done, err}, 36'd0);
                end else begin
                    monEv = sbQ.pop_front();
                    checkOutput("cmdCycle", 36'(cyc), 36'(monEv.cyc));
                    checkOutput("cmdCode", {33'd0, cmd_code}, {33'd0, monEv.code});
                    checkOutput("done", {35'd0, done}, {35'd0, monEv.isDone});
                    checkOutput("err", {35'd0, err}, {35'd0, monEv.isErr});
                    if (monEv.code != 3'd0) begin
                        checkOutput("fields", {8'd0, cmd_row, cmd_col, cmd_bank, cmd_bg, cmd_channel},
                                    {8'd0, monEv.addr[33:18], monEv.addr[17:12], monEv.addr[11:10],
                                     monEv.addr[9:7], monEv.addr[6]});
                    end
                end
            end
            if (!cmd_valid && cmd_code != 3'd0) begin
                checkOutput("nopCode", {33'd0, cmd_code}, 36'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int b, e;
        logic [35:0] rndAddr;

        repeat (3) @(negedge clk);
        checkOutput("readyInReset", {35'd0, req_ready}, 36'd0);
        rst = 1'b0;
        #1;
        checkOutput("readyAfterReset", {35'd0, req_ready}, 36'd1);
        checkOutput("resetOutputs", {8'd0, cmd_row, cmd_col, cmd_bank, cmd_bg, cmd_channel}, 36'd0);
        checkOutput("resetCtrl", {30'd0, cmd_valid, cmd_code, done, err}, 36'd0);
        started = 1'b1;

`ifdef MSD_OPEN_PAGE_EN
        applyStimulus(2'd0, ADDR_ROW5, K_OPENACT, b, e);
        applyStimulus(2'd0, ADDR_ROW5, K_HIT, b, e);
        checkOutput("hitAcceptCycle", 36'(b), 36'(lastCas - 1));
        applyStimulus(2'd0, ADDR_ROW6, K_MISS, b, e);
        applyStimulus(2'd2, ADDR_ROW6, K_HIT, b, e);
        waitCycle(e);
        checkOutput("readyAtEnd", {35'd0, req_ready}, 36'd1);
        waitCycle(e + 20);
`else
        applyStimulus(2'd0, ADDR_ROW5, K_CLOSED, b, e);
        checkOutput("readReadyCycle", 36'(e - b), 36'd116);
        waitCycle(e - 1);
        checkOutput("readReadyLow", {35'd0, req_ready}, 36'd0);
        waitCycle(e);
        checkOutput("readReadyHigh", {35'd0, req_ready}, 36'd1);

        applyStimulus(2'd2, ADDR_ROW5, K_CLOSED, b, e);
        waitCycle(e - 1);
        checkOutput("writeReadyLow", {35'd0, req_ready}, 36'd0);
        waitCycle(e);
        checkOutput("writeReadyHigh", {35'd0, req_ready}, 36'd1);

        applyStimulus(2'd1, ADDR_ROW5, K_CLOSED, b, e);
        waitCycle(e);
        checkOutput("fetchReadyHigh", {35'd0, req_ready}, 36'd1);

        applyStimulus(2'd3, ADDR_ROW5, K_ILLEGAL, b, e);
        checkOutput("illegalReady1", {35'd0, req_ready}, 36'd1);
        waitCycle(b + 2);
        checkOutput("illegalReady2", {35'd0, req_ready}, 36'd1);
        checkOutput("illegalNoCmd", {35'd0, cmd_valid}, 36'd0);

        applyStimulus(2'd0, ADDR_ROW6, K_NOPRE, b, e);
        waitCycle(b + 45);
        rst = 1'b1;
        waitCycle(b + 46);
        checkOutput("midResetValid", {35'd0, cmd_valid}, 36'd0);
        checkOutput("midResetReady", {35'd0, req_ready}, 36'd0);
        waitCycle(b + 47);
        rst = 1'b0;
        #1;
        checkOutput("postResetReady", {35'd0, req_ready}, 36'd1);
        waitCycle(b + 160);

        rndAddr = {4'($urandom_range(15)), 32'($urandom)};
        applyStimulus(2'd2, rndAddr, K_CLOSED, b, e);
        waitCycle(e);
        checkOutput("randReadyHigh", {35'd0, req_ready}, 36'd1);
        rndAddr = {4'($urandom_range(15)), 32'($urandom)};
        applyStimulus(2'd0, rndAddr, K_CLOSED, b, e);
        waitCycle(e + 5);
`endif
        checkOutput("sbEmpty", 36'(sbQ.size()), 36'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msd_cmd_sequencer.md
Name: msd_cmd_sequencer

Overview:
- Synthesizable DDR5 command sequencer between the memory-controller request queue and the DIMM command bus.
- Accepts one queued request (operation + 36-bit physical address) per handshake and decodes the address.
- Issues the two-cycle ACT0/ACT1, RD0/RD1 or WR0/WR1, then PRE command sequence, enforcing DRAM timing with internal counters.
- Default policy is closed-page; one request is outstanding at a time.

Parameters:
- T_RCD, 39: cycles from ACT0 to RD0/WR0.
- T_RAS, 76: minimum cycles from ACT0 to PRE.
- T_RP, 39: cycles from PRE until the next ACT0 is allowed.
- T_RTP, 18: minimum cycles from RD0 to PRE.
- T_CWD, 38: write latency, counted from WR0.
- T_BURST, 8: data burst length in cycles.
- T_WR, 30: write recovery time, counted after the write burst ends.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present at the queue head.
- req_ready  out  1  sequencer can accept a request.
- req_oper  in  2  0 = data read, 1 = instruction fetch, 2 = write, 3 = illegal.
- req_addr  in  36  physical address.
- cmd_valid  out  1  a command is on the bus this cycle.
- cmd_code  out  3  0 NOP, 1 ACT0, 2 ACT1, 3 RD0, 4 RD1, 5 WR0, 6 WR1, 7 PRE.
- cmd_channel  out  1  addr[6].
- cmd_bg  out  3  addr[9:7].
- cmd_bank  out  2  addr[11:10].
- cmd_col  out  6  addr[17:12].
- cmd_row  out  16  addr[33:18].
- done  out  1  one-cycle pulse when the request completes.
- err  out  1  one-cycle pulse when an illegal operation is dropped.

Behaviour:
- Reset values: req_ready=0 during reset and 1 on the first cycle after it. All other outputs are 0: cmd_valid, cmd_code, cmd_channel, cmd_bg, cmd_bank, cmd_col, cmd_row, done, err. The FSM resets to IDLE and all counters clear.
- Accept: a transfer occurs when req_valid && req_ready are high at a clk edge. oper and addr are registered on that edge. req_ready is high only in IDLE.
- Field outputs: hold the registered decode for the whole sequence; they are don't-care when cmd_valid=0.
- FSM states: IDLE, ACT0, ACT1, WAIT_RCD, CAS0, CAS1, WAIT_PRE, PRE, WAIT_RP.
- Transitions:
  - IDLE to ACT0 on accept. oper=3 instead stays in IDLE and pulses err the next cycle; no commands are issued.
  - ACT0 to ACT1 unconditionally. ACT0 is issued exactly 1 cycle after accept (cycle A).
  - ACT1 to WAIT_RCD.
  - WAIT_RCD to CAS0 when cycle = A+T_RCD. With T_RCD=2, WAIT_RCD lasts zero cycles.
  - CAS0 to CAS1. RD0/RD1 for oper 0/1; WR0/WR1 for oper 2.
  - CAS1 to WAIT_PRE.
  - WAIT_PRE to PRE at cycle P:
    - read: P = max(A+T_RAS, C+T_RTP), where C is the CAS0 cycle;
    - write: P = max(A+T_RAS, C+T_CWD+T_BURST+T_WR).
  - PRE: done pulses in the same cycle; then to WAIT_RP.
  - WAIT_RP to IDLE at cycle P+T_RP. req_ready rises that cycle.
- cmd_valid is 1 exactly in ACT0, ACT1, CAS0, CAS1 and PRE; cmd_code=0 otherwise.
- Counters: 8-bit saturating "cycles since ACT0" and "cycles since CAS0". Every parameter must lie in 2..255; otherwise compile-time $error.
- req_valid high outside IDLE: ignored; the request stays pending upstream.
- req_addr[35:34] and [5:0]: ignored.
- Reset mid-sequence: return to IDLE on the next edge. No PRE is issued and done is not pulsed.

Optional Feature:
- MSD_OPEN_PAGE_EN defined: open-page policy.
  - A 64-entry open-row table, indexed by {channel, bg, bank}, holds a valid bit and a 16-bit row each.
  - Row hit: CAS0 is issued 1 cycle after accept, provided the global "since last ACT0" counter is at least T_RCD.
  - Bank closed: ACT path as in closed-page.
  - Row miss: PRE, wait T_RP, then ACT path. PRE obeys T_RAS and T_RTP or write recovery, measured from the last ACT0 and last CAS0 globally.
  - No trailing PRE. done pulses on CAS1, and IDLE is re-entered the cycle after CAS1.
  - The table is cleared by rst.
- MSD_OPEN_PAGE_EN undefined: closed-page behaviour exactly as above; no table is instantiated.

Test Plan:
1. Read, closed-page, defaults: accept oper=0, addr=36'h0_0014_3540 at cycle 0.
   - ACT0 @1 and ACT1 @2 with ch=1 bg=2 bank=1 row=5.
   - RD0 @40 and RD1 @41 with col=3.
   - PRE and done @77; req_ready high @116.
2. Write, same address, accepted at cycle 0: WR0 @40, WR1 @41, PRE and done @116, req_ready @155.
3. Instruction fetch, oper=1: command stream identical to scenario 1 (RD0/RD1, not WR).
4. Illegal op, oper=3, accepted at cycle 0: err=1 @1; cmd_valid stays 0; req_ready stays 1.
5. Reset mid-operation: assert rst at cycle 45 during WAIT_PRE.
   - @46: cmd_valid=0, req_ready=0.
   - First cycle after rst deasserts: req_ready=1.
   - No PRE and no done.
6. MSD_OPEN_PAGE_EN defined: two reads to addr 36'h0_0014_3540, the second offered the cycle IDLE returns.
   - Second request issues RD0 1 cycle after accept, with no ACT and no PRE.
   - A third read to row 6 of the same bank issues PRE first, then ACT0 T_RP cycles later.
